// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: pipelined opcode decoder with ID/EX, EX/MEM, MEM/WB control registers,
// load-use bubble insertion, branch flush and a saturating stall counter.
// Ports: clk, rst (async, active-high); id_valid/id_opcode/id_rs/id_rt describe the ID-stage instruction;
// flush kills younger instructions when a branch resolves in MEM; id_stall holds PC and IF/ID;
// ex_*/mem_*/wb_* are the per-stage controls; stall_count counts inserted bubbles (saturating).
// Optional macro PIPE_CTRL_IMM_EN adds ADDI and J decode plus the ex_jump output.
module pipelined_control_unit #(
  parameter int OPCODE_W  = 6,
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int HAZARD_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_AW-1:0]   id_rs,
  input  logic [REG_AW-1:0]   id_rt,
  input  logic                flush,
  output logic                id_stall,
  output logic                ex_regdst,
  output logic                ex_alusrc,
  output logic [1:0]          ex_aluop,
  output logic                mem_branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                wb_memtoreg,
  output logic                wb_reg_write,
  output logic [CNT_W-1:0]    stall_count
`ifdef PIPE_CTRL_IMM_EN
  ,
  output logic                ex_jump
`endif
);
  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
`ifdef PIPE_CTRL_IMM_EN
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
`endif
  typedef struct packed {
    logic       regdst;
    logic       alusrc;
    logic       memtoreg;
    logic       branch;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] aluop;
`ifdef PIPE_CTRL_IMM_EN
    logic       jump;
`endif
  } ctrl_t;
  ctrl_t             dec;
  ctrl_t             ex;
  logic [REG_AW-1:0] ex_rt;
  logic              mem_memtoreg;
  logic              mem_reg_write;
  logic              kill_id;
  always_comb begin
    dec = '0;
    if (id_valid) begin
      if (id_opcode == OP_R) begin
        dec.regdst    = 1'b1;
        dec.reg_write = 1'b1;
        dec.aluop     = 2'b10;
      end else if (id_opcode == OP_LW) begin
        dec.alusrc    = 1'b1;
        dec.memtoreg  = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end else if (id_opcode == OP_SW) begin
        dec.alusrc    = 1'b1;
        dec.mem_write = 1'b1;
      end else if (id_opcode == OP_BEQ) begin
        dec.branch    = 1'b1;
        dec.aluop     = 2'b01;
`ifdef PIPE_CTRL_IMM_EN
      end else if (id_opcode == OP_ADDI) begin
        dec.alusrc    = 1'b1;
        dec.reg_write = 1'b1;
      end else if (id_opcode == OP_J) begin
        dec.jump      = 1'b1;
`endif
      end
    end
  end
  // A taken branch outranks the load-use hazard: the dependent instruction is being killed anyway.
  assign id_stall = (HAZARD_EN != 0) & ex.mem_read & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt)) & ~flush;
`ifdef PIPE_CTRL_IMM_EN
  // A J in EX squashes its delay slot on the way into ID/EX.
  assign kill_id = flush | id_stall | ex.jump;
  assign ex_jump = ex.jump;
`else
  assign kill_id = flush | id_stall;
`endif
  assign ex_regdst = ex.regdst;
  assign ex_alusrc = ex.alusrc;
  assign ex_aluop  = ex.aluop;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex            <= '0;
      ex_rt         <= '0;
      mem_branch    <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_memtoreg  <= 1'b0;
      mem_reg_write <= 1'b0;
      wb_memtoreg   <= 1'b0;
      wb_reg_write  <= 1'b0;
      stall_count   <= '0;
    end else begin
      ex            <= kill_id ? '0 : dec;
      ex_rt         <= id_rt;
      mem_branch    <= ex.branch & ~flush;
      mem_read      <= ex.mem_read & ~flush;
      mem_write     <= ex.mem_write & ~flush;
      mem_memtoreg  <= ex.memtoreg & ~flush;
      mem_reg_write <= ex.reg_write & ~flush;
      wb_memtoreg   <= mem_memtoreg;
      wb_reg_write  <= mem_reg_write;
      if (id_stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule
